// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU between two valid/ready requesters.
// The bench shares this file's module name, so keep it as the design top.
module alu_share_arb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_data1_i,
  input  logic [WIDTH-1:0] req0_data2_i,
  input  logic [2:0]       req0_ctrl_i,
  output logic             rsp0_valid_o,
  output logic [WIDTH-1:0] rsp0_data_o,
  input  logic             rsp0_ready_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_data1_i,
  input  logic [WIDTH-1:0] req1_data2_i,
  input  logic [2:0]       req1_ctrl_i,
  output logic             rsp1_valid_o,
  output logic [WIDTH-1:0] rsp1_data_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i
);

  localparam int unsigned CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [2:0]  CTRL_MUL = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             r_state;
  logic               r_last_grant;
  logic               r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_data1;
  logic [WIDTH-1:0]   r_data2;
  logic [2:0]         r_ctrl;
  logic [WIDTH-1:0]   r_result;
  logic               r_rsp0_valid;
  logic               r_rsp1_valid;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_idle;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_data1;
  logic [WIDTH-1:0]   w_sel_data2;
  logic [2:0]         w_sel_ctrl;
  logic               w_rsp_ack;
  logic               w_exec;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_grant0    = req0_valid_i && (!req1_valid_i || r_last_grant);
    w_grant1    = req1_valid_i && (!req0_valid_i || !r_last_grant);
    w_idle      = (r_state == S_IDLE) && rst_i;
    w_accept    = w_idle && (w_grant0 || w_grant1);
    w_sel_data1 = w_grant1 ? req1_data1_i : req0_data1_i;
    w_sel_data2 = w_grant1 ? req1_data2_i : req0_data2_i;
    w_sel_ctrl  = w_grant1 ? req1_ctrl_i  : req0_ctrl_i;
    w_rsp_ack   = r_owner ? (r_rsp1_valid && rsp1_ready_i)
                          : (r_rsp0_valid && rsp0_ready_i);
    w_exec      = (r_state == S_EXEC);
  end

  assign req0_ready_o = w_idle && w_grant0;
  assign req1_ready_o = w_idle && w_grant1;

  // ALU inputs are presented only while executing; zero otherwise.
  assign alu_data1_o  = w_exec ? r_data1 : '0;
  assign alu_data2_o  = w_exec ? r_data2 : '0;
  assign alu_ctrl_o   = w_exec ? r_ctrl  : 3'd0;

  assign rsp0_valid_o = r_rsp0_valid;
  assign rsp1_valid_o = r_rsp1_valid;
  assign rsp0_data_o  = r_rsp0_valid ? r_result : '0;
  assign rsp1_data_o  = r_rsp1_valid ? r_result : '0;

  // Sequencer: accept, hold operands for the op latency, then return the result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_data1      <= '0;
      r_data2      <= '0;
      r_ctrl       <= 3'd0;
      r_result     <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data1 <= w_sel_data1;
            r_data2 <= w_sel_data2;
            r_ctrl  <= w_sel_ctrl;
            r_owner <= w_grant1;
            r_cnt   <= (w_sel_ctrl == CTRL_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_result     <= alu_data_i;
            r_rsp0_valid <= !r_owner;
            r_rsp1_valid <= r_owner;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_ack) begin
            r_last_grant <= r_owner;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU on the shared port.
module tb_alu_share_arb;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_d1;
  logic [1:0][31:0]  req_d2;
  logic [1:0][2:0]   req_ctrl;
  logic [1:0]        rsp_valid;
  logic [1:0][31:0]  rsp_data;
  logic [1:0]        rsp_ready;
  logic [31:0]       alu_d1;
  logic [31:0]       alu_d2;
  logic [2:0]        alu_ctrl;
  logic [31:0]       alu_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(32), .MUL_LAT(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .req0_valid_i (req_valid[0]),
    .req0_ready_o (req_ready[0]),
    .req0_data1_i (req_d1[0]),
    .req0_data2_i (req_d2[0]),
    .req0_ctrl_i  (req_ctrl[0]),
    .rsp0_valid_o (rsp_valid[0]),
    .rsp0_data_o  (rsp_data[0]),
    .rsp0_ready_i (rsp_ready[0]),
    .req1_valid_i (req_valid[1]),
    .req1_ready_o (req_ready[1]),
    .req1_data1_i (req_d1[1]),
    .req1_data2_i (req_d2[1]),
    .req1_ctrl_i  (req_ctrl[1]),
    .rsp1_valid_o (rsp_valid[1]),
    .rsp1_data_o  (rsp_data[1]),
    .rsp1_ready_i (rsp_ready[1]),
    .alu_data1_o  (alu_d1),
    .alu_data2_o  (alu_d2),
    .alu_ctrl_o   (alu_ctrl),
    .alu_data_i   (alu_res)
  );

  // Shared combinational ALU
  always_comb begin
    case (alu_ctrl)
      3'd1:    alu_res = alu_d1 + alu_d2;
      3'd2:    alu_res = alu_d1 - alu_d2;
      3'd3:    alu_res = alu_d1 & alu_d2;
      3'd4:    alu_res = alu_d1 | alu_d2;
      3'd5:    alu_res = alu_d1 * alu_d2;
      default: alu_res = 32'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [2:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs [10];

  // One full transaction on port p: accept, count EXEC cycles, check response, acknowledge.
  task automatic do_op(input int p, input logic [2:0] ctrl, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] exp, input int cyc,
                       input string nm);
    int n;
    bit got;
    bit hold_bad;
    n = 0; got = 0; hold_bad = 0;
    @(posedge clk); #1;
    req_valid[p] = 1'b1; req_d1[p] = d1; req_d2[p] = d2; req_ctrl[p] = ctrl;
    @(negedge clk);
    chk({nm, " ready"}, 32'(req_ready[p]), 32'd1);
    chk({nm, " other_ready"}, 32'(req_ready[1-p]), 32'd0);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[p]) got = 1;
      else begin
        n++;
        if (alu_ctrl !== ctrl || alu_d1 !== d1 || alu_d2 !== d2) hold_bad = 1;
      end
    end
    chk({nm, " rsp_timeout"}, 32'(got), 32'd1);
    chk({nm, " exec_cycles"}, 32'(n), 32'(cyc));
    chk({nm, " alu_hold"}, 32'(hold_bad), 32'd0);
    chk({nm, " rsp_data"}, rsp_data[p], exp);
    chk({nm, " other_valid"}, 32'(rsp_valid[1-p]), 32'd0);
    chk({nm, " other_data"}, rsp_data[1-p], 32'd0);
    chk({nm, " alu_ctrl_resp"}, 32'(alu_ctrl), 32'd0);
    chk({nm, " ready_resp"}, 32'(req_ready), 32'd0);
    rsp_ready[p] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[p] = 1'b0;
    @(negedge clk);
    chk({nm, " rsp_drop"}, 32'(rsp_valid[p]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int who;
    bit got;
    bit bad;
    logic [31:0] bexp [2];

    vecs[0] = '{0, 3'd1, 32'd7,        32'd5,        32'd12,         1};
    vecs[1] = '{1, 3'd5, 32'h0001_0000, 32'h0001_0000, 32'h0,         3};
    vecs[2] = '{0, 3'd2, 32'd9,        32'd10,       32'hFFFF_FFFF,  1};
    vecs[3] = '{1, 3'd4, 32'hF0,       32'h0F,       32'hFF,         1};
    vecs[4] = '{0, 3'd6, 32'd3,        32'd4,        32'd0,          1};
    vecs[5] = '{1, 3'd3, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1};
    vecs[6] = '{0, 3'd5, 32'd6,        32'd7,        32'd42,         3};
    vecs[7] = '{1, 3'd0, 32'd11,       32'd13,       32'd0,          1};
    vecs[8] = '{0, 3'd1, 32'hFFFF_FFFF, 32'd2,        32'd1,          1};
    vecs[9] = '{1, 3'd7, 32'd5,        32'd6,        32'd0,          1};

    rst_n = 1'b0; req_valid = '0; req_d1 = '0; req_d2 = '0; req_ctrl = '0; rsp_ready = '0;
    req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("reset alu_d1", alu_d1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid[0] = 1'b0;

    for (int v = 0; v < 10; v++)
      do_op(vecs[v].port, vecs[v].ctrl, vecs[v].d1, vecs[v].d2, vecs[v].exp, vecs[v].cyc,
            $sformatf("vec%0d", v));

    // Reset asserted in the middle of a multiply
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_d1[0] = 32'd6; req_d2[0] = 32'd7; req_ctrl[0] = 3'd5;
    @(negedge clk);
    chk("mr ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr exec_ctrl", 32'(alu_ctrl), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("mr alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("mr alu_d1", alu_d1, 32'd0);
    chk("mr alu_d2", alu_d2, 32'd0);
    chk("mr ready", 32'(req_ready), 32'd0);
    chk("mr rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr rsp_data0", rsp_data[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid[0] = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || alu_ctrl != 3'd0) bad = 1;
    end
    chk("mr no_stale", 32'(bad), 32'd0);

    // Both requesters valid continuously: grants alternate starting with 0
    @(posedge clk); #1;
    req_d1[0] = 32'd9;   req_d2[0] = 32'd10;  req_ctrl[0] = 3'd2;
    req_d1[1] = 32'hF0;  req_d2[1] = 32'h0F;  req_ctrl[1] = 3'd4;
    bexp[0] = 32'hFFFF_FFFF; bexp[1] = 32'hFF;
    rsp_ready = 2'b11; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) got = 1;
      end
      chk($sformatf("rr%0d grant_timeout", k), 32'(got), 32'd1);
      chk($sformatf("rr%0d one_hot", k), 32'(req_ready == 2'b11), 32'd0);
      who = req_ready[1] ? 1 : 0;
      chk($sformatf("rr%0d grant", k), 32'(who), 32'(k % 2));
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (rsp_valid[who]) got = 1;
      end
      chk($sformatf("rr%0d rsp_timeout", k), 32'(got), 32'd1);
      chk($sformatf("rr%0d rsp_data", k), rsp_data[who], bexp[who]);
    end
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 2'b00;

    // Back-pressure on response 0 while requester 1 waits
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_d1[0] = 32'd1; req_d2[0] = 32'd2; req_ctrl[0] = 3'd1;
    @(negedge clk);
    chk("bp ready0", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_d1[1] = 32'd10; req_d2[1] = 32'd20; req_ctrl[1] = 3'd1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) got = 1;
    end
    chk("bp rsp_timeout", 32'(got), 32'd1);
    bad = 0;
    repeat (5) begin
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd3 || req_ready !== 2'b00) bad = 1;
      @(negedge clk);
    end
    chk("bp hold", 32'(bad), 32'd0);
    chk("bp data", rsp_data[0], 32'd3);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk("bp rsp0_drop", 32'(rsp_valid[0]), 32'd0);
    chk("bp ready1", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) got = 1;
    end
    chk("bp rsp1_timeout", 32'(got), 32'd1);
    chk("bp rsp1_data", rsp_data[1], 32'd30);
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    chk("bp rsp1_drop", 32'(rsp_valid[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
